muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS multicycle datapath.
- The ALU control path forwards R-type funct codes here for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Performs iterative shift-add multiply and restoring divide, one bit per cycle, and signals completion with a start/busy/done handshake.
- The main FSM stalls on busy and reads results through MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring-divide bit per cycle, start/busy/done handshake, MT*/MF* access.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, divz_q, divz_d, ill_q, ill_d;

  // Operand conditioning: signed ops work on magnitudes, signs fixed up in FIX
  logic             sgn_op, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign sgn_op = (funct == F_MULT) || (funct == F_DIV);
  assign sa     = sgn_op & a[WIDTH-1];
  assign sb     = sgn_op & b[WIDTH-1];
  assign abs_a  = sa ? -a : a;
  assign abs_b  = sb ? -b : b;

  // Multiply step: add multiplicand into upper half, shift whole product right
  logic [WIDTH:0] msum;
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Restoring divide step; dividend/quotient share acc_q[WIDTH-1:0]
  logic [WIDTH:0] rem_sh, rdiff;
  logic           qbit;
  assign rem_sh = {rem_q, acc_q[WIDTH-1]};
  assign rdiff  = rem_sh - {1'b0, opb_q};
  assign qbit   = ~rdiff[WIDTH];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divz_d    = 1'b0;
    ill_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d   = S_RUN;
              cnt_d     = '0;
              acc_d     = {{WIDTH{1'b0}}, abs_a};
              rem_d     = '0;
              opb_d     = abs_b;
              is_div_d  = (funct == F_DIV) || (funct == F_DIVU);
              neg_res_d = sa ^ sb;
              neg_rem_d = sa;
              dz_d      = ((funct == F_DIV) || (funct == F_DIVU)) && (b == '0);
            end
            F_MTHI:         hi_d  = a;
            F_MTLO:         lo_d  = a;
            F_MFHI, F_MFLO: ;
            default:        ill_d = 1'b1;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            rem_d = qbit ? rdiff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
          end else begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        divz_d  = dz_q;
        if (is_div_q) begin
          // Divide by zero leaves |a| in the remainder, so the sign fix restores a
          hi_d = rem_fix;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
      ill_q     <= ill_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = divz_q;
  assign illegal  = ill_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_data  = (funct == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboard of expected HI/LO per op,
// plus MT/MF access, illegal funct, mid-op reset and an 8-bit instance.
module tb_muldiv_unit;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] FBAD = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero, illegal;
  logic [31:0] hi, lo, rd_data;

  logic        start8 = 1'b0;
  logic [5:0]  funct8 = 6'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, div_zero8, illegal8;
  logic [7:0]  hi8, lo8, rd_data8;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal),
    .hi(hi), .lo(lo), .rd_data(rd_data));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .funct(funct8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .illegal(illegal8),
    .hi(hi8), .lo(lo8), .rd_data(rd_data8));

  typedef struct {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, p, q, r;
    logic [63:0] up, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0; e.hi = '0; e.lo = '0;
    case (f)
      MULT:  begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      MULTU: begin up = {32'b0, x} * {32'b0, y}; e.hi = up[63:32]; e.lo = up[31:0]; end
      DIV:
        if (y == 0) begin e.dz = 1'b1; e.hi = x; e.lo = '1; end
        else begin q = sx / sy; r = sx % sy; e.hi = r[31:0]; e.lo = q[31:0]; end
      DIVU:
        if (y == 0) begin e.dz = 1'b1; e.hi = x; e.lo = '1; end
        else begin uq = {32'b0, x} / {32'b0, y}; ur = {32'b0, x} % {32'b0, y}; e.hi = ur[31:0]; e.lo = uq[31:0]; end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one arithmetic op; optionally inject a start at cycle inj_at while busy.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] oa, input logic [31:0] ob,
                        input int inj_at, input logic [5:0] inj_f, input logic [31:0] inj_a);
    exp_t e;
    int   n;
    bit   seen_ill;
    sbq.push_back(model(f, oa, ob));
    @(negedge clk);
    start = 1'b1; funct = f; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    chk({tag, "_accept_busy"}, {63'b0, busy}, 64'd1);
    chk({tag, "_prev_done_low"}, {62'b0, done, div_zero}, 64'd0);
    n = 0; seen_ill = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (illegal) seen_ill = 1;
      if (done) break;
      if (n == inj_at) begin start = 1'b1; funct = inj_f; a = inj_a; b = 32'h3; end
      else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    e = sbq.pop_front();
    chk({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
    chk({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
    chk({tag, "_divzero"}, {63'b0, div_zero}, {63'b0, e.dz});
    chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
    chk({tag, "_no_illegal"}, {63'b0, seen_ill}, 64'd0);
    last_lo = e.lo;
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_flags", {61'b0, done, div_zero, illegal}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mult_7_m3", MULT, 32'd7, 32'hFFFFFFFD, 0, MFLO, '0);
    chk("mult_7_m3_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 0, MFLO, '0);
    chk("divu_lit", {hi, lo}, {32'd2, 32'd14});
    run_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 0, MFLO, '0);
    run_op("div_zero", DIV, 32'h12345678, 32'd0, 0, MFLO, '0);
    chk("div_zero_lit", {hi, lo}, 64'h12345678_FFFFFFFF);
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, MFLO, '0);
    run_op("mult_ignore_start", MULT, 32'h00001234, 32'hFFFFFFFB, 5, MULT, 32'h7FFFFFFF);
    run_op("mtlo_while_busy", MULT, 32'd3, 32'd4, 5, MTLO, 32'h55555555);
    run_op("div_overflow", DIV, 32'h80000000, 32'hFFFFFFFF, 3, FBAD, 32'h0);
    run_op("div_neg_rem", DIV, 32'd7, 32'hFFFFFFFE, 0, MFLO, '0);
    run_op("divu_zero", DIVU, 32'h80000001, 32'd0, 0, MFLO, '0);

    // MTHI then combinational MFHI / MFLO reads
    @(negedge clk); start = 1'b1; funct = MTHI; a = 32'hCAFEF00D;
    @(posedge clk); #1; start = 1'b0;
    chk("mthi_hi", {32'b0, hi}, {32'b0, 32'hCAFEF00D});
    chk("mthi_no_busy", {62'b0, busy, done}, 64'd0);
    funct = MFHI; #1;
    chk("mfhi_rd", {32'b0, rd_data}, {32'b0, 32'hCAFEF00D});
    funct = MFLO; #1;
    chk("mflo_rd", {32'b0, rd_data}, {32'b0, last_lo});

    // Unsupported funct: one-cycle illegal pulse
    @(negedge clk); start = 1'b1; funct = FBAD;
    @(posedge clk); #1; start = 1'b0;
    chk("illegal_pulse", {62'b0, illegal, busy}, 64'd2);
    @(posedge clk); #1;
    chk("illegal_clear", {63'b0, illegal}, 64'd0);

    // Reset in the middle of a divide
    @(negedge clk); start = 1'b1; funct = DIV; a = 32'hFFFFFF9C; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {62'b0, busy, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("divu_9_3", DIVU, 32'd9, 32'd3, 0, MFLO, '0);
    chk("divu_9_3_lit", {hi, lo}, {32'd0, 32'd3});

    // 8-bit instance: -128 * -128
    @(negedge clk); start8 = 1'b1; funct8 = MULT; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1; start8 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done8) break;
    end
    chk("w8_latency", 64'(n), 64'd10);
    chk("w8_hilo", {48'b0, hi8, lo8}, {48'b0, 8'h40, 8'h00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
